// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the decode stage and its register file.
// Contents: instruction-code constants, register-specifier constants and the
// default datapath width. No ports.
package y86_pkg;

  localparam int WIDTH_DEF = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovxx
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

endpackage

// File: rtl/regfile_2w2r.sv
// Architectural register storage with two write ports and two bypassed
// read ports, plus an un-bypassed debug read port.
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears storage)
//   dst_e_i/val_e_i      write port E (RNONE = no write)
//   dst_m_i/val_m_i      write port M (RNONE = no write), wins over E
//   rd_a_idx_i/rd_a_o    read port A, sees same-cycle writes (M before E)
//   rd_b_idx_i/rd_b_o    read port B, same bypass as A
//   dbg_idx_i/dbg_val_o  storage-only read; 0 for RNONE or out-of-range index
module regfile_2w2r
  import y86_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       dst_e_i,
  input  logic [WIDTH-1:0] val_e_i,
  input  logic [3:0]       dst_m_i,
  input  logic [WIDTH-1:0] val_m_i,
  input  logic [3:0]       rd_a_idx_i,
  output logic [WIDTH-1:0] rd_a_o,
  input  logic [3:0]       rd_b_idx_i,
  output logic [WIDTH-1:0] rd_b_o,
  input  logic [3:0]       dbg_idx_i,
  output logic [WIDTH-1:0] dbg_val_o
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  // Indices at or above NREG (other than RNONE) have no storage behind them.
  function automatic logic in_range(input logic [3:0] idx);
    return (idx != RNONE) && (int'(idx) < NREG);
  endfunction

  // Bypassed read: a write landing this edge is visible to the reader now,
  // with M taking priority to mirror the write priority below.
  function automatic logic [WIDTH-1:0] bypass_read(
    input logic [3:0]       idx,
    input logic [3:0]       dst_e,
    input logic [WIDTH-1:0] val_e,
    input logic [3:0]       dst_m,
    input logic [WIDTH-1:0] val_m,
    input logic [WIDTH-1:0] stored
  );
    if (idx == RNONE)       return '0;
    else if (idx == dst_m)  return val_m;
    else if (idx == dst_e)  return val_e;
    else                    return stored;
  endfunction

  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  always_comb begin
    stored_a  = '0;
    stored_b  = '0;
    dbg_val_o = '0;
    if (in_range(rd_a_idx_i)) stored_a  = regs_q[rd_a_idx_i];
    if (in_range(rd_b_idx_i)) stored_b  = regs_q[rd_b_idx_i];
    if (in_range(dbg_idx_i))  dbg_val_o = regs_q[dbg_idx_i];
  end

  assign rd_a_o = bypass_read(rd_a_idx_i, dst_e_i, val_e_i, dst_m_i, val_m_i, stored_a);
  assign rd_b_o = bypass_read(rd_b_idx_i, dst_e_i, val_e_i, dst_m_i, val_m_i, stored_b);

  // Next-state storage: M is checked first so dstE==dstM resolves to valM
  // (popq %rsp). Out-of-range indices match no entry and are dropped.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (dst_m_i == 4'(i))      regs_d[i] = val_m_i;
      else if (dst_e_i == 4'(i)) regs_d[i] = val_e_i;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) regs_q[i] <= '0;
      else     regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: rtl/decode_reg_read.sv
// Y86-64 decode-stage register read: resolves srcA/srcB from icode, reads
// the register file (with write-back bypass) and registers the result as a
// one-cycle pipeline stage. Also owns the write-back write path.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid, stall            upstream valid, downstream hold
//   icode, rA, rB              instruction fields from fetch
//   dstE/valE, dstM/valM       write-back writes (4'hF = none)
//   out_valid, srcA, srcB,
//   valA, valB                 registered decode results
//   dbg_idx, dbg_val           combinational storage-only debug read
//
// Handshake: a transfer is accepted on a rising edge where stall=0; then
// out_valid takes in_valid and, if in_valid=1, src*/val* load the freshly
// resolved values. When stall=1 every output holds, including data whose
// source register is being written -- the hazard unit must not stall
// across a dependent write. When in_valid=0 only out_valid drops.
module decode_reg_read
  import y86_pkg::*;
#(
  parameter int          WIDTH   = WIDTH_DEF,
  parameter int          NREG    = 15,
  parameter logic [3:0]  RSP_IDX = RSP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [3:0]       dstE,
  input  logic [WIDTH-1:0] valE,
  input  logic [3:0]       dstM,
  input  logic [WIDTH-1:0] valM,
  output logic             out_valid,
  output logic [3:0]       srcA,
  output logic [3:0]       srcB,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  input  logic [3:0]       dbg_idx,
  output logic [WIDTH-1:0] dbg_val
);

  logic [3:0]       src_a_c;
  logic [3:0]       src_b_c;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Source select; unknown icodes fall to RNONE, which reads as 0.
  always_comb begin
    src_a_c = RNONE;
    src_b_c = RNONE;
    case (icode)
      I_RRMOVQ: src_a_c = rA;
      I_RMMOVQ: begin src_a_c = rA;      src_b_c = rB;      end
      I_MRMOVQ: src_b_c = rB;
      I_OPQ:    begin src_a_c = rA;      src_b_c = rB;      end
      I_CALL:   src_b_c = RSP_IDX;
      I_RET:    begin src_a_c = RSP_IDX; src_b_c = RSP_IDX; end
      I_PUSHQ:  begin src_a_c = rA;      src_b_c = RSP_IDX; end
      I_POPQ:   begin src_a_c = RSP_IDX; src_b_c = RSP_IDX; end
      default:  ;
    endcase
  end

  regfile_2w2r #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .dst_e_i    (dstE),
    .val_e_i    (valE),
    .dst_m_i    (dstM),
    .val_m_i    (valM),
    .rd_a_idx_i (src_a_c),
    .rd_a_o     (rd_a),
    .rd_b_idx_i (src_b_c),
    .rd_b_o     (rd_b),
    .dbg_idx_i  (dbg_idx),
    .dbg_val_o  (dbg_val)
  );

  logic             out_valid_q, out_valid_d;
  logic [3:0]       src_a_q, src_a_d;
  logic [3:0]       src_b_q, src_b_d;
  logic [WIDTH-1:0] val_a_q, val_a_d;
  logic [WIDTH-1:0] val_b_q, val_b_d;

  always_comb begin
    out_valid_d = out_valid_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    if (!stall) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        src_a_d = src_a_c;
        src_b_d = src_b_c;
        val_a_d = rd_a;
        val_b_d = rd_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      src_a_q     <= RNONE;
      src_b_q     <= RNONE;
      val_a_q     <= '0;
      val_b_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign srcA      = src_a_q;
  assign srcB      = src_b_q;
  assign valA      = val_a_q;
  assign valB      = val_b_q;

endmodule

// File: tb/tb_decode_reg_read.sv
module tb_decode_reg_read;

  localparam int W    = 64;
  localparam int NREG = 15;
  localparam int EW   = 8 + 2 * W;  // {srcA, srcB, valA, valB}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         stall = 1'b0;
  logic [3:0]   icode = 4'h1;
  logic [3:0]   rA = 4'hF;
  logic [3:0]   rB = 4'hF;
  logic [3:0]   dstE = 4'hF;
  logic [W-1:0] valE = '0;
  logic [3:0]   dstM = 4'hF;
  logic [W-1:0] valM = '0;
  logic [3:0]   dbg_idx = 4'h0;

  logic         out_valid;
  logic [3:0]   srcA, srcB;
  logic [W-1:0] valA, valB, dbg_val;

  decode_reg_read dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .stall     (stall),
    .icode     (icode),
    .rA        (rA),
    .rB        (rB),
    .dstE      (dstE),
    .valE      (valE),
    .dstM      (dstM),
    .valM      (valM),
    .out_valid (out_valid),
    .srcA      (srcA),
    .srcB      (srcB),
    .valA      (valA),
    .valB      (valB),
    .dbg_idx   (dbg_idx),
    .dbg_val   (dbg_val)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  model_regs [NREG];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: which registers each instruction reads.
  function automatic logic [3:0] ref_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return ra;
    if (ic == 4'hB || ic == 4'h9) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return rb;
    if (ic == 4'hA || ic == 4'hB || ic == 4'h8 || ic == 4'h9) return 4'h4;
    return 4'hF;
  endfunction

  // Value a reader sees this cycle: pending writes are already visible.
  function automatic logic [W-1:0] ref_read(input logic [3:0] s);
    if (s == 4'hF) return '0;
    if (s == dstM) return valM;
    if (s == dstE) return valE;
    if (int'(s) >= NREG) return '0;
    return model_regs[s];
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle's inputs at the falling edge, pushes the expected
  // output if the coming edge loads the stage, then commits the model's
  // register writes for that edge.
  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] de, input logic [W-1:0] ve,
                       input logic [3:0] dm, input logic [W-1:0] vm,
                       input logic [3:0] di);
    logic [3:0] sa, sb;
    @(negedge clk);
    rst = r; in_valid = v; stall = s; icode = ic; rA = ra; rB = rb;
    dstE = de; valE = ve; dstM = dm; valM = vm; dbg_idx = di;
    if (!r && !s && v) begin
      sa = ref_src_a(ic, ra);
      sb = ref_src_b(ic, rb);
      exp_q.push_back({sa, sb, ref_read(sa), ref_read(sb)});
    end
    if (r) begin
      for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    end else begin
      if (de != 4'hF && int'(de) < NREG) model_regs[de] = ve;
      if (dm != 4'hF && int'(dm) < NREG) model_regs[dm] = vm;
    end
  endtask

  task automatic idle(input logic [3:0] di);
    drive(1'b0, 1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF, '0, 4'hF, '0, di);
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] held = {4'hF, 4'hF, {W{1'b0}}, {W{1'b0}}};
  logic          held_v = 1'b0;

  initial begin
    logic r, s, v;
    logic [EW-1:0] e;
    logic [W-1:0]  dexp;
    forever begin
      @(posedge clk);
      r = rst; s = stall; v = in_valid;
      #1;
      if (r) begin
        held   = {4'hF, 4'hF, {W{1'b0}}, {W{1'b0}}};
        held_v = 1'b0;
      end else if (!s) begin
        held_v = v;
        if (v) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: output load with no expected entry (t=%0t)", $time);
          end else begin
            held = exp_q.pop_front();
          end
        end
      end
      e = held;
      check("out_valid", W'(out_valid), W'(held_v));
      check("srcA", W'(srcA), W'(e[EW-1 -: 4]));
      check("srcB", W'(srcB), W'(e[EW-5 -: 4]));
      check("valA", valA, e[2*W-1 -: W]);
      check("valB", valB, e[W-1:0]);
      dexp = (dbg_idx == 4'hF || int'(dbg_idx) >= NREG) ? '0 : model_regs[dbg_idx];
      check("dbg_val", dbg_val, dexp);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;

    // Reset then read
    drive(1'b1, 1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF, '0, 4'hF, '0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 4'h6, 4'h1, 4'h2, 4'hF, '0, 4'hF, '0, 4'h1);
    // Write then read
    drive(1'b0, 1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'h3, 64'h1234, 4'hF, '0, 4'h3);
    drive(1'b0, 1'b1, 1'b0, 4'h6, 4'h3, 4'hF, 4'hF, '0, 4'hF, '0, 4'h3);
    @(posedge clk); #2;
    check("direct_valA_0x1234", valA, 64'h1234);
    // Same-cycle bypass with M priority on pushq
    drive(1'b0, 1'b1, 1'b0, 4'hA, 4'h0, 4'hF, 4'h4, 64'h10, 4'h4, 64'h20, 4'h4);
    idle(4'h4);
    @(posedge clk); #2;
    check("direct_dbg_reg4_0x20", dbg_val, 64'h20);
    // Stack sources
    drive(1'b0, 1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'h4, 64'h100, 4'hF, '0, 4'h4);
    drive(1'b0, 1'b1, 1'b0, 4'hB, 4'h0, 4'hF, 4'hF, '0, 4'hF, '0, 4'h4);
    drive(1'b0, 1'b1, 1'b0, 4'h8, 4'h0, 4'hF, 4'hF, '0, 4'hF, '0, 4'h4);
    drive(1'b0, 1'b1, 1'b0, 4'h9, 4'h0, 4'hF, 4'hF, '0, 4'hF, '0, 4'h4);
    // Stall hold, including a write to the held source register
    drive(1'b0, 1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'h5, 64'h5, 4'hF, '0, 4'h5);
    drive(1'b0, 1'b1, 1'b0, 4'h2, 4'h5, 4'hF, 4'hF, '0, 4'hF, '0, 4'h5);
    drive(1'b0, 1'b1, 1'b1, 4'h6, 4'h1, 4'h2, 4'h5, 64'h77, 4'hF, '0, 4'h5);
    drive(1'b0, 1'b1, 1'b1, 4'h4, 4'h3, 4'h4, 4'hF, '0, 4'hF, '0, 4'h5);
    drive(1'b0, 1'b0, 1'b1, 4'h9, 4'h0, 4'h0, 4'hF, '0, 4'hF, '0, 4'h5);
    drive(1'b0, 1'b1, 1'b0, 4'h2, 4'h5, 4'hF, 4'hF, '0, 4'hF, '0, 4'h5);
    // Invalid icodes and in_valid drop
    drive(1'b0, 1'b1, 1'b0, 4'hD, 4'h1, 4'h2, 4'hF, '0, 4'hF, '0, 4'h1);
    idle(4'h2);
    // Reset overrides a same-edge write; write to F changes nothing
    drive(1'b1, 1'b1, 1'b1, 4'h6, 4'h1, 4'h1, 4'h1, 64'hABCD, 4'hF, '0, 4'h1);
    drive(1'b0, 1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF, 64'hDEAD, 4'hF, 64'hBEEF, 4'h1);
    drive(1'b0, 1'b1, 1'b0, 4'h6, 4'h1, 4'h2, 4'hF, '0, 4'hF, '0, 4'hF);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] de, dm;
      de = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      dm = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      if ($urandom_range(0, 9) == 0) dm = de;
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            de, {$urandom, $urandom},
            dm, {$urandom, $urandom},
            4'($urandom_range(0, 15)));
    end
    idle(4'h0);
    idle(4'h0);
    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
